// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the 5-stage pipeline hazard sequencer.
//   fwd_sel_t  : EX operand source select (register file, WB result, MEM result)
//   hz_state_t : memory-wait sequencer states
//   REG_ZERO   : architectural x0, never a forwarding or hazard source
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles every pipeline-facing signal of the hazard sequencer.
//   Inputs to the sequencer : ID/EX/MEM/WB register specifiers, load and
//                             write-enable flags, resolved PC source, and the
//                             data-memory request/ready handshake.
//   Outputs of the sequencer: PC/IF-ID/back-end stalls, IF-ID and ID-EX
//                             flushes, EX forwarding selects, sticky timeout
//                             error and the stall-cycle counter.
//   modport master : the pipeline datapath side
//   modport slave  : the hazard_ctrl side
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_id_i;
    logic [4:0]       rs2_id_i;
    logic [4:0]       rs1_ex_i;
    logic [4:0]       rs2_ex_i;
    logic [4:0]       rd_ex_i;
    logic             MemRead_ex_i;
    logic             PCsrc_ex_i;
    logic             RegWrite_mem_i;
    logic [4:0]       rd_mem_i;
    logic             RegWrite_wb_i;
    logic [4:0]       rd_wb_i;
    logic             mem_req_i;
    logic             mem_ready_i;

    logic             stall_pc_o;
    logic             stall_id_o;
    logic             stall_ex_o;
    logic             flush_id_o;
    logic             flush_ex_o;
    logic [1:0]       fwdA_o;
    logic [1:0]       fwdB_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output rs1_id_i, rs2_id_i, rs1_ex_i, rs2_ex_i, rd_ex_i,
        output MemRead_ex_i, PCsrc_ex_i,
        output RegWrite_mem_i, rd_mem_i, RegWrite_wb_i, rd_wb_i,
        output mem_req_i, mem_ready_i,
        input  stall_pc_o, stall_id_o, stall_ex_o,
        input  flush_id_o, flush_ex_o,
        input  fwdA_o, fwdB_o, err_o, stall_cnt_o
    );

    modport slave (
        input  rs1_id_i, rs2_id_i, rs1_ex_i, rs2_ex_i, rd_ex_i,
        input  MemRead_ex_i, PCsrc_ex_i,
        input  RegWrite_mem_i, rd_mem_i, RegWrite_wb_i, rd_wb_i,
        input  mem_req_i, mem_ready_i,
        output stall_pc_o, stall_id_o, stall_ex_o,
        output flush_id_o, flush_ex_o,
        output fwdA_o, fwdB_o, err_o, stall_cnt_o
    );

endinterface

// File: rtl/hazard_ctrl_forward_unit.sv
// ---------------------------------------------------------------------------
// forward_unit
// Combinational EX operand bypass selection.
//   rs1_ex / rs2_ex       : source registers of the instruction in EX
//   reg_write_mem, rd_mem : destination of the instruction in MEM
//   reg_write_wb,  rd_wb  : destination of the instruction in WB
//   fwd_a / fwd_b         : operand-1 / operand-2 source select
// The MEM result is younger than the WB result, so it wins when both match.
// ---------------------------------------------------------------------------
module forward_unit
    import pipe_pkg::*;
(
    input  logic [4:0] rs1_ex,
    input  logic [4:0] rs2_ex,
    input  logic       reg_write_mem,
    input  logic [4:0] rd_mem,
    input  logic       reg_write_wb,
    input  logic [4:0] rd_wb,
    output fwd_sel_t   fwd_a,
    output fwd_sel_t   fwd_b
);

    // Writes to x0 are discarded by the register file, so they never bypass.
    function automatic fwd_sel_t pick_source(input logic [4:0] rs);
        fwd_sel_t sel;
        sel = FWD_REG;
        if (reg_write_mem && rd_mem != REG_ZERO && rd_mem == rs) begin
            sel = FWD_MEM;
        end else if (reg_write_wb && rd_wb != REG_ZERO && rd_wb == rs) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Both operands use the same priority rule against their own source.
    always_comb begin
        fwd_a = pick_source(rs1_ex);
        fwd_b = pick_source(rs2_ex);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencer for the 5-stage core.
//   clk_i : clock, all state updates on the rising edge
//   rst_i : synchronous active-high reset
//   hz    : hazard_ctrl_if.slave bundle (hazard inputs, stall/flush/forward
//           controls, sticky err_o and saturating stall_cnt_o)
// Parameters:
//   TIMEOUT : cycles allowed in MEM_WAIT before the sticky error (>= 2)
//   CNT_W   : stall-cycle counter width
// Priority of the stage controls, highest first: reset, memory freeze,
// taken branch/jump, load-use.
// ---------------------------------------------------------------------------
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_ctrl_if.slave hz
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    hz_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;
    logic [CNT_W-1:0]  stall_cnt;

    fwd_sel_t          fwd_a;
    fwd_sel_t          fwd_b;
    logic              mem_freeze;
    logic              load_use;
    logic              stall_pc;
    logic              stall_id;
    logic              stall_ex;
    logic              flush_id;
    logic              flush_ex;

    forward_unit u_forward_unit (
        .rs1_ex        (hz.rs1_ex_i),
        .rs2_ex        (hz.rs2_ex_i),
        .reg_write_mem (hz.RegWrite_mem_i),
        .rd_mem        (hz.rd_mem_i),
        .reg_write_wb  (hz.RegWrite_wb_i),
        .rd_wb         (hz.rd_wb_i),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    // The whole pipeline freezes while a data access is outstanding. The
    // request cycle itself already freezes unless memory answers at once,
    // and the cycle where ready arrives is released so the pipeline advances.
    always_comb begin
        mem_freeze = ((state == RUN) && hz.mem_req_i && !hz.mem_ready_i) ||
                     ((state == MEM_WAIT) && !hz.mem_ready_i) ||
                     (state == ERR);
        load_use   = hz.MemRead_ex_i && (hz.rd_ex_i != REG_ZERO) &&
                     ((hz.rd_ex_i == hz.rs1_id_i) || (hz.rd_ex_i == hz.rs2_id_i));
    end

    // Stage control resolution. During reset the front of the pipe is
    // bubbled so whatever was in flight is discarded. A taken branch
    // squashes the younger instructions, which makes a load-use stall
    // on the squashed ID instruction pointless.
    always_comb begin
        stall_pc = 1'b0;
        stall_id = 1'b0;
        stall_ex = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (rst_i) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (mem_freeze) begin
            stall_pc = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
        end else if (hz.PCsrc_ex_i) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (load_use) begin
            stall_pc = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
    end

    // Memory-wait sequencer plus the sticky error and the stall counter.
    // wait_cnt holds the number of frozen cycles already spent on the
    // current access; reaching TIMEOUT of them without ready is fatal
    // until reset. The stall counter clamps at all-ones for profiling.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hz.mem_req_i && !hz.mem_ready_i) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (hz.mem_ready_i) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        state <= ERR;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERR: begin
                    state <= ERR;
                    err_q <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
            if ((stall_pc || stall_id || stall_ex) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // Drive the interface outputs; during reset forwarding is forced off.
    always_comb begin
        hz.stall_pc_o  = stall_pc;
        hz.stall_id_o  = stall_id;
        hz.stall_ex_o  = stall_ex;
        hz.flush_id_o  = flush_id;
        hz.flush_ex_o  = flush_ex;
        hz.fwdA_o      = rst_i ? 2'b00 : fwd_a;
        hz.fwdB_o      = rst_i ? 2'b00 : fwd_b;
        hz.err_o       = err_q;
        hz.stall_cnt_o = stall_cnt;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl with TIMEOUT=4 and CNT_W=4 so that the
// timeout and counter saturation are reachable in a short run. Expected
// outputs are queued when each stimulus cycle is driven and compared at the
// following falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
    import pipe_pkg::*;

    typedef struct {
        string      tag;
        logic       spc;
        logic       sid;
        logic       sex;
        logic       fid;
        logic       fex;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       err;
        logic [3:0] cnt;
    } expT;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   expCnt;
    expT  sbQ[$];

    hazard_ctrl_if #(.CNT_W(4)) hz();

    hazard_ctrl #(
        .TIMEOUT (4),
        .CNT_W   (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic clearInputs();
        hz.rs1_id_i       = '0;
        hz.rs2_id_i       = '0;
        hz.rs1_ex_i       = '0;
        hz.rs2_ex_i       = '0;
        hz.rd_ex_i        = '0;
        hz.MemRead_ex_i   = 1'b0;
        hz.PCsrc_ex_i     = 1'b0;
        hz.RegWrite_mem_i = 1'b0;
        hz.rd_mem_i       = '0;
        hz.RegWrite_wb_i  = 1'b0;
        hz.rd_wb_i        = '0;
        hz.mem_req_i      = 1'b0;
        hz.mem_ready_i    = 1'b0;
    endtask

    // Queue the expectation for the inputs currently applied, compare at the
    // falling edge, then step one clock and update the counter model.
    task automatic applyStimulus(input string tag,
                                 input logic spc, input logic sid, input logic sex,
                                 input logic fid, input logic fex,
                                 input logic [1:0] fa, input logic [1:0] fb,
                                 input logic err);
        expT e;
        expT o;
        e.tag = tag;
        e.spc = spc;
        e.sid = sid;
        e.sex = sex;
        e.fid = fid;
        e.fex = fex;
        e.fa  = fa;
        e.fb  = fb;
        e.err = err;
        e.cnt = 4'(expCnt);
        sbQ.push_back(e);
        @(negedge clk);
        o = sbQ.pop_front();
        checkOutput({o.tag, ".stall_pc"}, 32'(hz.stall_pc_o), 32'(o.spc));
        checkOutput({o.tag, ".stall_id"}, 32'(hz.stall_id_o), 32'(o.sid));
        checkOutput({o.tag, ".stall_ex"}, 32'(hz.stall_ex_o), 32'(o.sex));
        checkOutput({o.tag, ".flush_id"}, 32'(hz.flush_id_o), 32'(o.fid));
        checkOutput({o.tag, ".flush_ex"}, 32'(hz.flush_ex_o), 32'(o.fex));
        checkOutput({o.tag, ".fwdA"}, 32'(hz.fwdA_o), 32'(o.fa));
        checkOutput({o.tag, ".fwdB"}, 32'(hz.fwdB_o), 32'(o.fb));
        checkOutput({o.tag, ".err"}, 32'(hz.err_o), 32'(o.err));
        checkOutput({o.tag, ".stall_cnt"}, 32'(hz.stall_cnt_o), 32'(o.cnt));
        @(posedge clk);
        #1;
        if (rst) begin
            expCnt = 0;
        end else if ((spc || sid || sex) && expCnt != 15) begin
            expCnt++;
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        expCnt = 0;
        rst    = 1'b1;
        clearInputs();
        @(posedge clk);
        #1;
        applyStimulus("reset", 0, 0, 0, 1, 1, 2'b00, 2'b00, 0);
        rst = 1'b0;
        applyStimulus("idle", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Forwarding priority and x0 exclusion.
        hz.rs1_ex_i = 5'd5; hz.rd_mem_i = 5'd5; hz.RegWrite_mem_i = 1'b1;
        hz.rd_wb_i = 5'd5; hz.RegWrite_wb_i = 1'b1;
        applyStimulus("fwd_mem_over_wb", 0, 0, 0, 0, 0, 2'b10, 2'b00, 0);
        hz.RegWrite_mem_i = 1'b0;
        applyStimulus("fwd_wb", 0, 0, 0, 0, 0, 2'b01, 2'b00, 0);
        hz.RegWrite_mem_i = 1'b1; hz.rd_mem_i = 5'd0; hz.rd_wb_i = 5'd0; hz.rs1_ex_i = 5'd0;
        applyStimulus("fwd_x0", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        hz.rs1_ex_i = 5'd3; hz.rd_mem_i = 5'd3; hz.rs2_ex_i = 5'd9; hz.rd_wb_i = 5'd9;
        applyStimulus("fwd_split", 0, 0, 0, 0, 0, 2'b10, 2'b01, 0);
        clearInputs();

        // Load-use: one stall cycle, then clear; rd=x0 never stalls.
        hz.MemRead_ex_i = 1'b1; hz.rd_ex_i = 5'd7; hz.rs2_id_i = 5'd7;
        applyStimulus("load_use", 1, 1, 0, 0, 1, 2'b00, 2'b00, 0);
        hz.MemRead_ex_i = 1'b0;
        applyStimulus("load_use_after", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        hz.MemRead_ex_i = 1'b1; hz.rd_ex_i = 5'd0; hz.rs1_id_i = 5'd0;
        applyStimulus("load_use_x0", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        clearInputs();

        // Branch overrides a simultaneous load-use and is not counted.
        hz.MemRead_ex_i = 1'b1; hz.rd_ex_i = 5'd7; hz.rs2_id_i = 5'd7; hz.PCsrc_ex_i = 1'b1;
        applyStimulus("branch_over_lu", 0, 0, 0, 1, 1, 2'b00, 2'b00, 0);
        clearInputs();
        applyStimulus("branch_after", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Three-cycle memory wait with a pending branch released on ready.
        hz.mem_req_i = 1'b1; hz.PCsrc_ex_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("mem_wait%0d", i), 1, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        end
        hz.mem_ready_i = 1'b1;
        applyStimulus("mem_release", 0, 0, 0, 1, 1, 2'b00, 2'b00, 0);
        clearInputs();
        applyStimulus("mem_back_run", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Zero-wait access stays in RUN.
        hz.mem_req_i = 1'b1; hz.mem_ready_i = 1'b1;
        applyStimulus("zero_wait", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        clearInputs();
        applyStimulus("zero_wait_after", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Timeout after four frozen cycles, ERR is absorbing.
        hz.mem_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("tmo_wait%0d", i), 1, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        end
        applyStimulus("tmo_err", 1, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        hz.mem_req_i = 1'b0;
        applyStimulus("err_sticky", 1, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        rst = 1'b1;
        hz.rs1_ex_i = 5'd4; hz.rd_mem_i = 5'd4; hz.RegWrite_mem_i = 1'b1;
        applyStimulus("err_reset", 0, 0, 0, 1, 1, 2'b00, 2'b00, 1);
        rst = 1'b0;
        clearInputs();
        applyStimulus("post_reset", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Twenty frozen cycles saturate the 4-bit counter at 15.
        hz.mem_req_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus($sformatf("sat%0d", i), 1, 1, 1, 0, 0, 2'b00, 2'b00, (i >= 4) ? 1'b1 : 1'b0);
        end
        applyStimulus("sat_hold", 1, 1, 1, 0, 0, 2'b00, 2'b00, 1);
        rst = 1'b1;
        clearInputs();
        applyStimulus("final_reset", 0, 0, 0, 1, 1, 2'b00, 2'b00, 1);
        rst = 1'b0;
        applyStimulus("final_idle", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
